mem_read_pipe: RTL
==================

MEM_READ_PIPE -- requirements
Module: mem_read_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 16-bit memory words; the address is 8 bits wide.
REQ-002 SHALL have parameter DW, default 16: data width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1 bit: write strobe from the upstream ALU pipeline's memory-write stage.
REQ-006 SHALL have port wr_addr, input, 8 bits: write address.
REQ-007 SHALL have port wr_data, input, 16 bits: write data.
REQ-008 SHALL have port req_valid, input, 1 bit: read request valid.
REQ-009 SHALL have port req_ready, output, 1 bit: read request accepted this cycle when both req_valid and req_ready are 1.
REQ-010 SHALL have port req_addr, input, 8 bits: read address.
REQ-011 SHALL have port req_rd, input, 4 bits: destination register tag, carried through unchanged.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-013 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-014 SHALL have port rsp_data, output, 16 bits: read data.
REQ-015 SHALL have port rsp_rd, output, 4 bits: tag that belongs with rsp_data.
REQ-016 SHALL have port rsp_count, output, 8 bits: count of completed responses.

Function
REQ-017 SHALL hold a DEPTH x DW memory; on posedge with wr_en=1, mem[wr_addr] becomes wr_data.
REQ-018 SHALL implement 2 registered stages:
  - S1: captures addr and tag.
  - S2: captures mem[S1 addr] plus the tag and drives the rsp_* outputs.
REQ-019 SHALL define advance = !s2_v || rsp_ready.
  - S2 loads from S1 only when advance=1.
  - S1 loads a new request only when advance=1 or s1_v=0.
REQ-020 SHALL drive req_ready = advance || !s1_v (combinational, no dependency on req_valid).
REQ-021 SHALL give latency: request accepted at edge N gives rsp_valid=1 after edge N+1, with rsp_ready held high throughout.
REQ-022 SHALL sustain one response per cycle when rsp_ready is held at 1.
REQ-023 SHALL hold rsp_data, rsp_rd and rsp_valid stable while rsp_valid=1 and rsp_ready=0; requests SHALL be neither lost nor duplicated.
REQ-024 SHALL clear s2_v when S2 drains and S1 is empty.
REQ-025 SHALL increment rsp_count on every rsp_valid && rsp_ready; it saturates at 255.
REQ-026 SHALL, for a write and an S1->S2 load to the same address on the same edge, select S2 data per REQ-031/REQ-032.
REQ-027 SHALL treat a request arriving while wr_en is high to any address as a normal request with no stall.

Reset
REQ-028 SHALL, while rst_n=0, force: s1_v=0, s2_v=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_count=0, req_ready=0.
REQ-029 SHALL discard all in-flight requests when reset is asserted mid-operation; memory contents SHALL NOT be reset.
REQ-030 SHALL assert req_ready=1 on the first cycle after rst_n rises.

Configuration
REQ-031 SHALL, with macro MEM_READ_PIPE_BYPASS_EN defined, forward wr_data into S2 when wr_en=1 and wr_addr equals the S1 address on the loading edge.
REQ-032 SHALL, without MEM_READ_PIPE_BYPASS_EN, capture the pre-write memory value in the REQ-026 case; the write still completes.

Verification
REQ-033 SHALL cover: write 0x1234 at address 0x05, then request addr 0x05 tag 3 with rsp_ready=1 -> rsp_valid two edges later with rsp_data=0x1234, rsp_rd=3, rsp_count=1.
REQ-034 SHALL cover: back-to-back requests to addresses 0x00..0x03 (preloaded 0xA0..0xA3) with rsp_ready=1 -> 4 consecutive responses 0xA0..0xA3, in order, one per cycle.
REQ-035 SHALL cover stall:
  - rsp_ready=0 for 5 cycles with 3 requests offered -> req_ready drops after 2 accepts, rsp_data held steady.
  - Releasing rsp_ready -> all 3 responses delivered in order.
REQ-036 SHALL cover: mem[0x10]=0x0001, then on the same edge write 0xBEEF to 0x10 while 0x10 moves S1->S2 -> rsp_data=0xBEEF with the bypass macro, 0x0001 without it; mem[0x10]=0xBEEF afterward in both cases.
REQ-037 SHALL cover: assert rst_n=0 with 2 requests in flight -> rsp_valid=0 immediately; after release, no stale response and rsp_count=0.
REQ-038 SHALL cover: 300 accepted responses -> rsp_count=255.

Source files
------------

// File: rtl/mem_read_pipe.sv
// mem_read_pipe: DEPTH x DW memory with a two-stage registered read pipeline.
// A write port from the upstream ALU pipeline updates the memory. A
// valid/ready request port feeds the pipe:
//   S1 holds the address and tag.
//   S2 holds the read data and tag, and drives the rsp_* outputs.
// Backpressure from rsp_ready stalls the pipe without losing or duplicating
// any request. rsp_count counts completed responses and saturates at 255.
// Optional feature: define MEM_READ_PIPE_BYPASS_EN to forward wr_data into S2
// when a write hits the address that is moving S1->S2 on the same edge.
// Without it, S2 captures the pre-write memory value; the write still lands.
module mem_read_pipe #(
  parameter int DEPTH = 256,
  parameter int DW    = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  // memory write port
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  // read request
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_rd,
  // read response
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [3:0]    rsp_rd,
  output logic [7:0]    rsp_count
);

  logic [DW-1:0] mem [DEPTH];

  logic          s1_v;
  logic [AW-1:0] s1_addr;
  logic [3:0]    s1_rd;
  logic          s2_v;

  logic          advance;
  logic          s1_load;
  logic [DW-1:0] s2_next_data;

  // S2 may take new data when it is empty or its response is being consumed;
  // S1 may take a request when S2 is advancing or S1 itself is empty.
  assign advance   = !s2_v || rsp_ready;
  assign s1_load   = advance || !s1_v;
  // Gated with rst_n so the port reads not-ready while reset is held.
  assign req_ready = rst_n && s1_load;
  assign rsp_valid = s2_v;

  // Memory write port.
  // NOTE: the memory has no reset; contents survive rst_n, and a resettable
  // array would keep it from mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Data that S2 captures on the next loading edge.
`ifdef MEM_READ_PIPE_BYPASS_EN
  always_comb begin
    // NOTE: default assignment first, so no path leaves the signal unassigned
    // and no latch is inferred.
    s2_next_data = mem[s1_addr];
    if (wr_en && (wr_addr == s1_addr)) begin
      s2_next_data = wr_data;
    end
  end
`else
  always_comb begin
    // The read sees the array before this edge's write commits, so a
    // colliding write yields the old value.
    s2_next_data = mem[s1_addr];
  end
`endif

  // Stage 1: capture request address and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state, so every
      // register samples pre-edge values regardless of block order.
      s1_v    <= 1'b0;
      s1_addr <= '0;
      s1_rd   <= '0;
    end else if (s1_load) begin
      s1_v    <= req_valid;
      s1_addr <= req_addr;
      s1_rd   <= req_rd;
    end
  end

  // Stage 2: capture read data and tag; holds while stalled by rsp_ready=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      rsp_data <= '0;
      rsp_rd   <= '0;
    end else if (advance) begin
      s2_v <= s1_v;
      if (s1_v) begin
        rsp_data <= s2_next_data;
        rsp_rd   <= s1_rd;
      end
    end
  end

  // Completed-response counter, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_count <= '0;
    end else if (rsp_valid && rsp_ready && (rsp_count != 8'hFF)) begin
      rsp_count <= rsp_count + 8'd1;
    end
  end

endmodule
